regfile_wb_ctrl: RTL and testbench
==================================

# regfile_wb_ctrl

Write-back controller for the 32 x 64-bit register file. It shares the file's single write port among `NREQ` write-back requesters (ALU, load unit, misc) using round-robin arbitration with a valid/ready handshake. It registers the winning write into the port, and keeps a busy scoreboard of destination registers that have been issued but not yet written. It sits between the execute/memory stages and `RegFile`; issue logic reads `busy` for RAW/WAW hazard stalls.

## Interface
Parameters:
- `NREQ`, 3: number of write-back requesters (2..4).
- `AW`, 5: register address width (32 entries).
- `DW`, 64: data width.

Ports:
- `clk`  in  1  clock; all logic rising-edge.
- `rst`  in  1  reset, synchronous, active-high.
- `req_valid`  in  NREQ  requester i has a write pending.
- `req_ready`  out  NREQ  requester i is accepted this cycle; one-hot or zero.
- `req_addr`  in  NREQ*AW  destination of requester i, at bits [i*AW +: AW].
- `req_data`  in  NREQ*DW  write data of requester i, at bits [i*DW +: DW].
- `rf_we`  out  1  register-file write enable.
- `rf_addrw`  out  AW  register-file write address.
- `rf_di`  out  DW  register-file write data.
- `issue_valid`  in  1  an instruction with a destination is issued this cycle.
- `issue_addr`  in  AW  destination register of the issued instruction.
- `flush`  in  1  pipeline flush; discards outstanding scoreboard state.
- `busy`  out  2^AW  scoreboard; bit r=1 means a write to r is outstanding.

## Operation
- **Arbitration (combinational)**
  - Search starts at pointer `ptr` and proceeds `ptr, ptr+1, …` mod NREQ.
  - The first i with `req_valid[i]=1` is granted: `req_ready[i]=1`.
  - At most one grant per cycle.
  - `req_ready` is all zero when no requester is valid, or when `flush=1`.
- **Handshake**
  - A transfer occurs on a cycle with `req_valid[i] & req_ready[i]`.
  - A requester holds valid, addr and data stable until that transfer.
  - `req_ready` may depend on `req_valid`.
  - Requesters must not make `req_valid` depend on `req_ready`.
- **Pointer update**
  - On a transfer from i: `ptr <= (i+1) mod NREQ`.
  - With no transfer, `ptr` holds.
- **Output stage**
  - A transfer from i in cycle N registers `rf_we=1`, `rf_addrw=req_addr[i]`, `rf_di=req_data[i]`, visible in cycle N+1.
  - With no transfer in cycle N, `rf_we=0` in N+1; `rf_addrw` and `rf_di` hold their old values.
  - The write port never back-pressures, so a new transfer is possible every cycle.
- **Scoreboard**
  - Set: `issue_valid` sets `busy[issue_addr]`.
  - Clear: `rf_we=1` clears `busy[rf_addrw]`. The clear happens on the same edge at which `RegFile` captures the write.
  - Simultaneous set and clear of the same register: set wins, because a newer writer is outstanding.
  - Set and clear of different registers in one cycle: both take effect.
- **Flush**
  - `flush=1` clears all `busy` bits on the next edge and suppresses grants that cycle.
  - A write already in the output stage (`rf_we=1`) still completes.
  - If `issue_valid` and `flush` are both high, flush wins and the bit ends at 0.
- **Register 0**
  - Register 0 gets no special treatment. Writes to 0 are performed and tracked like any other register.

## Timing
- Reset values: `rf_we=0`, `rf_addrw=0`, `rf_di=0`, `busy=0`, `ptr=0`.
  - `req_ready` is therefore ready-from-pointer-0 in the first cycle after reset.
- Reset asserted mid-operation: any transfer in that cycle is dropped, and every output takes its reset value on the next edge.
- Latency:
  - Accept (cycle N) to `rf_we` (cycle N+1): 1 cycle.
  - Accept to `busy` clear: 2 edges, i.e. `busy` low in cycle N+2.
  - Issue (cycle M) to `busy` high: cycle M+1.
- Throughput: 1 write per cycle. Under full load each requester gets 1 of every NREQ cycles.
- `busy` is purely registered, with no combinational path from inputs.

## Structure
- Shared package holds:
  - `RF_AW=5` and `RF_DW=64`.
  - A `rf_wr_t` struct {we, addr, data} used on the `RegFile` write port.
- One sub-module, `rr_arbiter`: parameterized NREQ round-robin picker with inputs req and ptr, outputs a one-hot grant and the encoded index. Reusable elsewhere in the codebase.
- The scoreboard and output register live in the top module.

## Test plan
- **Reset.** Hold `rst` 2 cycles with all req_valid=1.
  - Required: `rf_we=0`, `busy=0` during reset.
  - Required: the first grant after release goes to requester 0.
- **Round-robin.** req_valid=3'b111 held for 6 cycles, addresses 1/2/3.
  - Required: grants 0,1,2,0,1,2.
  - Required: `rf_addrw` sequence 1,2,3,1,2,3 delayed by one cycle, with `rf_we` high continuously.
- **Pointer skip.** After a grant to requester 0, req_valid=3'b101.
  - Required: grant goes to requester 2, then 0.
  - Required: requester 1 asserting valid later is granted before 0 is granted again.
- **Scoreboard.** Issue addr 7 in cycle 0 (busy[7]=1 in cycle 1); requester 1 writes addr 7 in cycle 3.
  - Required: `rf_we`, addr 7 in cycle 4; busy[7]=0 in cycle 5.
- **Set/clear collision.** In the cycle where `rf_we` writes addr 9, also assert issue_valid with addr 9.
  - Required: busy[9] remains 1.
- **Flush.** Flush with busy bits {3,7} set, a write to 5 in the output stage, and issue_valid to 12.
  - Required: the write to 5 completes.
  - Required: busy=0 next cycle; no `req_ready` during the flush cycle.

Source files
------------

// File: rtl/regfile_wb_ctrl_pkg.sv
// Shared definitions for the register-file write-back path.
// Holds the register-file geometry and the write-port record.
package regfile_wb_ctrl_pkg;

  localparam int RF_AW = 5;
  localparam int RF_DW = 64;

  typedef struct packed {
    logic             we;
    logic [RF_AW-1:0] addr;
    logic [RF_DW-1:0] data;
  } rf_wr_t;

endpackage

// File: rtl/regfile_wb_ctrl_rr_arbiter.sv
// Round-robin picker: grants the first requester found when
// searching from ptr upward, wrapping modulo N.
module rr_arbiter #(
  parameter int N  = 3,
  parameter int PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic [PW-1:0] idx
);

  logic found;
  int   cand;

  // Priority rotates with ptr; only the first hit along the search wins.
  always_comb begin
    grant = '0;
    idx   = '0;
    found = 1'b0;
    cand  = 0;
    for (int k = 0; k < N; k++) begin
      cand = int'(ptr) + k;
      if (cand >= N) cand = cand - N;
      if (!found && req[cand]) begin
        grant[cand] = 1'b1;
        idx         = PW'(cand);
        found       = 1'b1;
      end
    end
  end

endmodule

// File: rtl/regfile_wb_ctrl.sv
// Write-back controller: arbitrates the register-file write port among
// NREQ requesters and tracks outstanding destinations in a busy scoreboard.
module regfile_wb_ctrl
  import regfile_wb_ctrl_pkg::*;
#(
  parameter int NREQ = 3,
  parameter int AW   = RF_AW,
  parameter int DW   = RF_DW
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREQ-1:0]      req_valid,
  output logic [NREQ-1:0]      req_ready,
  input  logic [NREQ*AW-1:0]   req_addr,
  input  logic [NREQ*DW-1:0]   req_data,
  output logic                 rf_we,
  output logic [AW-1:0]        rf_addrw,
  output logic [DW-1:0]        rf_di,
  input  logic                 issue_valid,
  input  logic [AW-1:0]        issue_addr,
  input  logic                 flush,
  output logic [(1<<AW)-1:0]   busy
);

  localparam int PW   = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int NREG = 1 << AW;

  logic [PW-1:0]   ptr;
  logic [PW-1:0]   idx;
  logic [NREQ-1:0] grant;
  logic            xfer;
  rf_wr_t          wr_q;
  logic [NREG-1:0] busy_q;
  logic [NREG-1:0] busy_next;

  rr_arbiter #(
    .N  (NREQ),
    .PW (PW)
  ) u_arb (
    .req   (req_valid),
    .ptr   (ptr),
    .grant (grant),
    .idx   (idx)
  );

  // The arbiter only grants valid requesters, so any ready bit is a transfer.
  assign req_ready = flush ? '0 : grant;
  assign xfer      = |req_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr <= '0;
    end else if (xfer) begin
      ptr <= (idx == PW'(NREQ - 1)) ? '0 : idx + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_q <= '0;
    end else begin
      wr_q.we <= xfer;
      if (xfer) begin
        wr_q.addr <= req_addr[int'(idx)*AW +: AW];
        wr_q.data <= req_data[int'(idx)*DW +: DW];
      end
    end
  end

  // Set after clear so a newly issued writer outlives the retiring one.
  always_comb begin
    busy_next = busy_q;
    if (flush) begin
      busy_next = '0;
    end else begin
      if (wr_q.we) busy_next[wr_q.addr] = 1'b0;
      if (issue_valid) busy_next[issue_addr] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) busy_q <= '0;
    else     busy_q <= busy_next;
  end

  assign rf_we    = wr_q.we;
  assign rf_addrw = wr_q.addr;
  assign rf_di    = wr_q.data;
  assign busy     = busy_q;

endmodule

// File: tb/tb_regfile_wb_ctrl.sv
// Self-checking bench for regfile_wb_ctrl: table-driven cycles plus
// hand-written flush/reset/register-0 sequences, with a write scoreboard.
module tb_regfile_wb_ctrl;

  localparam int NREQ = 3;
  localparam int AW   = 5;
  localparam int DW   = 64;

  logic                clk = 1'b0;
  logic                rst;
  logic [NREQ-1:0]     req_valid;
  logic [NREQ-1:0]     req_ready;
  logic [NREQ*AW-1:0]  req_addr;
  logic [NREQ*DW-1:0]  req_data;
  logic                rf_we;
  logic [AW-1:0]       rf_addrw;
  logic [DW-1:0]       rf_di;
  logic                issue_valid;
  logic [AW-1:0]       issue_addr;
  logic                flush;
  logic [31:0]         busy;

  always #5 clk = ~clk;

  regfile_wb_ctrl #(.NREQ(NREQ), .AW(AW), .DW(DW)) dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_addr    (req_addr),
    .req_data    (req_data),
    .rf_we       (rf_we),
    .rf_addrw    (rf_addrw),
    .rf_di       (rf_di),
    .issue_valid (issue_valid),
    .issue_addr  (issue_addr),
    .flush       (flush),
    .busy        (busy)
  );

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } wr_item_t;

  typedef struct {
    string      name;
    logic       rst;
    logic [2:0] valid;
    logic [14:0] addrs;
    logic       iv;
    logic [4:0] ia;
    logic       fl;
    logic [2:0] exp_ready;
  } vec_t;

  wr_item_t    exp_q[$];
  vec_t        vecs[$];
  int          tests;
  int          fails;
  logic        pending;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_di;
  logic [31:0] m_busy;

  function automatic logic [14:0] pack_addrs(logic [4:0] a0, logic [4:0] a1, logic [4:0] a2);
    return {a2, a1, a0};
  endfunction

  task automatic check_output(string name, logic [63:0] act, logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // One cycle: drive, check against the model mid-cycle, advance the model, clock.
  task automatic apply_stimulus(string name, logic r, logic [2:0] v, logic [14:0] addrs,
                                logic iv, logic [4:0] ia, logic fl, logic [2:0] exp_ready);
    wr_item_t item;
    logic     exp_we;
    rst         = r;
    req_valid   = v;
    req_addr    = addrs;
    issue_valid = iv;
    issue_addr  = ia;
    flush       = fl;
    #3;
    exp_we = pending;
    if (exp_we) begin
      if (exp_q.size() == 0) begin
        check_output({name, ".queue"}, 64'd0, 64'd1);
      end else begin
        item   = exp_q.pop_front();
        m_addr = item.addr;
        m_di   = item.data;
      end
    end
    check_output({name, ".rf_we"}, 64'(rf_we), 64'(exp_we));
    check_output({name, ".rf_addrw"}, 64'(rf_addrw), 64'(m_addr));
    check_output({name, ".rf_di"}, rf_di, m_di);
    check_output({name, ".busy"}, 64'(busy), 64'(m_busy));
    if (!r) check_output({name, ".req_ready"}, 64'(req_ready), 64'(exp_ready));
    pending = 1'b0;
    if (r) begin
      exp_q.delete();
      m_busy = '0;
      m_addr = '0;
      m_di   = '0;
    end else begin
      if (fl) begin
        m_busy = '0;
      end else begin
        if (exp_we) m_busy[m_addr] = 1'b0;
        if (iv) m_busy[ia] = 1'b1;
      end
      for (int i = 0; i < NREQ; i++) begin
        if (exp_ready[i]) begin
          exp_q.push_back({addrs[i*AW +: AW], req_data[i*DW +: DW]});
          pending = 1'b1;
        end
      end
    end
    @(posedge clk);
    #1;
    for (int i = 0; i < NREQ; i++) begin
      if (exp_ready[i] && !r) req_data[i*DW +: DW] = {$urandom, $urandom};
    end
  endtask

  initial begin
    tests = 0;
    fails = 0;
    rst = 1'b1;
    req_valid = '0;
    req_addr = '0;
    issue_valid = 1'b0;
    issue_addr = '0;
    flush = 1'b0;
    for (int i = 0; i < NREQ; i++) req_data[i*DW +: DW] = {$urandom, $urandom};
    @(posedge clk);
    #1;
    pending = 1'b0;
    m_addr = '0;
    m_di = '0;
    m_busy = '0;

    vecs.push_back('{"rst0",  1, 3'b111, pack_addrs(1, 2, 3), 0, 0, 0, 3'b000});
    vecs.push_back('{"rst1",  1, 3'b111, pack_addrs(1, 2, 3), 0, 0, 0, 3'b000});
    vecs.push_back('{"rr0",   0, 3'b111, pack_addrs(1, 2, 3), 0, 0, 0, 3'b001});
    vecs.push_back('{"rr1",   0, 3'b111, pack_addrs(1, 2, 3), 0, 0, 0, 3'b010});
    vecs.push_back('{"rr2",   0, 3'b111, pack_addrs(1, 2, 3), 0, 0, 0, 3'b100});
    vecs.push_back('{"rr3",   0, 3'b111, pack_addrs(1, 2, 3), 0, 0, 0, 3'b001});
    vecs.push_back('{"rr4",   0, 3'b111, pack_addrs(1, 2, 3), 0, 0, 0, 3'b010});
    vecs.push_back('{"rr5",   0, 3'b111, pack_addrs(1, 2, 3), 0, 0, 0, 3'b100});
    vecs.push_back('{"skip0", 0, 3'b001, pack_addrs(4, 2, 6), 0, 0, 0, 3'b001});
    vecs.push_back('{"skip1", 0, 3'b101, pack_addrs(4, 2, 6), 0, 0, 0, 3'b100});
    vecs.push_back('{"skip2", 0, 3'b101, pack_addrs(4, 2, 6), 0, 0, 0, 3'b001});
    vecs.push_back('{"skip3", 0, 3'b111, pack_addrs(4, 8, 6), 0, 0, 0, 3'b010});
    vecs.push_back('{"skip4", 0, 3'b101, pack_addrs(4, 8, 6), 0, 0, 0, 3'b100});
    vecs.push_back('{"idle0", 0, 3'b000, pack_addrs(0, 0, 0), 0, 0, 0, 3'b000});
    vecs.push_back('{"sb0",   0, 3'b000, pack_addrs(0, 0, 0), 1, 7, 0, 3'b000});
    vecs.push_back('{"sb1",   0, 3'b000, pack_addrs(0, 0, 0), 0, 0, 0, 3'b000});
    vecs.push_back('{"sb2",   0, 3'b000, pack_addrs(0, 0, 0), 0, 0, 0, 3'b000});
    vecs.push_back('{"sb3",   0, 3'b010, pack_addrs(0, 7, 0), 0, 0, 0, 3'b010});
    vecs.push_back('{"sb4",   0, 3'b000, pack_addrs(0, 0, 0), 0, 0, 0, 3'b000});
    vecs.push_back('{"sb5",   0, 3'b000, pack_addrs(0, 0, 0), 1, 9, 0, 3'b000});
    vecs.push_back('{"col0",  0, 3'b100, pack_addrs(0, 0, 9), 0, 0, 0, 3'b100});
    vecs.push_back('{"col1",  0, 3'b000, pack_addrs(0, 0, 0), 1, 9, 0, 3'b000});
    vecs.push_back('{"col2",  0, 3'b000, pack_addrs(0, 0, 0), 1, 3, 0, 3'b000});
    vecs.push_back('{"col3",  0, 3'b001, pack_addrs(5, 0, 0), 1, 7, 0, 3'b001});

    foreach (vecs[n]) begin
      apply_stimulus(vecs[n].name, vecs[n].rst, vecs[n].valid, vecs[n].addrs,
                     vecs[n].iv, vecs[n].ia, vecs[n].fl, vecs[n].exp_ready);
    end

    // Flush with busy {3,7,9}, a write to 5 in the output stage, and an issue to 12.
    apply_stimulus("flush0", 0, 3'b111, pack_addrs(1, 2, 3), 1, 12, 1, 3'b000);
    apply_stimulus("flush1", 0, 3'b000, pack_addrs(0, 0, 0), 0, 0, 0, 3'b000);

    // Reset mid-operation drops the pending grant and restarts at requester 0.
    apply_stimulus("mrst0", 0, 3'b111, pack_addrs(1, 2, 3), 0, 0, 0, 3'b010);
    apply_stimulus("mrst1", 1, 3'b111, pack_addrs(1, 2, 3), 1, 4, 0, 3'b000);
    apply_stimulus("mrst2", 0, 3'b111, pack_addrs(1, 2, 3), 0, 0, 0, 3'b001);

    // Register 0 is tracked and written like any other.
    apply_stimulus("r0_0", 0, 3'b000, pack_addrs(0, 0, 0), 1, 0, 0, 3'b000);
    apply_stimulus("r0_1", 0, 3'b001, pack_addrs(0, 0, 0), 0, 0, 0, 3'b001);
    apply_stimulus("r0_2", 0, 3'b000, pack_addrs(0, 0, 0), 0, 0, 0, 3'b000);
    apply_stimulus("r0_3", 0, 3'b000, pack_addrs(0, 0, 0), 0, 0, 0, 3'b000);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
